// File: rtl/cnt_bcd_display_if.sv
// cnt_bcd_display_if: bundle between the display stage and its environment.
//   cnt       : 7-bit binary count into the converter
//   bcd       : latched 3-digit BCD result {hundreds, tens, units}
//   busy      : conversion FSM not idle
//   conv_done : one-cycle pulse when a new bcd value appears
//   an        : one-hot digit enable (an[0]=units, an[2]=hundreds)
//   seg       : active-high segments {g,f,e,d,c,b,a} for the enabled digit
// Modports: master = environment side (drives cnt), slave = display stage.
interface cnt_bcd_display_if;
  logic [6:0]  cnt;
  logic [11:0] bcd;
  logic        busy;
  logic        conv_done;
  logic [2:0]  an;
  logic [6:0]  seg;

  modport master (output cnt, input bcd, busy, conv_done, an, seg);
  modport slave  (input cnt, output bcd, busy, conv_done, an, seg);
endinterface

// File: rtl/cnt_bcd_display.sv
// cnt_bcd_display: converts a 7-bit count to three BCD digits with a
// sequential shift-add-3 engine and drives a 3-digit multiplexed
// seven-segment display. A conversion starts only when cnt differs from the
// last value captured.
// Parameters:
//   SCAN_DIV : clock cycles each digit stays enabled (>= 1)
// Ports:
//   i_clk : system clock, rising edge
//   i_rst : asynchronous reset, active-high
//   bus   : cnt_bcd_display_if.slave (cnt in; bcd, busy, conv_done, an, seg out)
// Optional feature macro: LEADING_ZERO_BLANK_EN -- blank leading zero digits
// (hundreds when zero; tens when hundreds and tens are zero).
module cnt_bcd_display #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  cnt_bcd_display_if.slave   bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [6:0]  r_sample;
  logic [6:0]  r_bin;
  logic [11:0] r_scratch;
  logic [2:0]  r_iter;
  logic [11:0] r_bcd;
  logic        r_done;
  logic [11:0] w_adj;
  logic [18:0] w_shift;
  logic        w_start;

  logic [PW-1:0] r_pre;
  logic [1:0]    r_digit;
  logic [3:0]    w_nib;
  logic          w_blank;

  assign w_start = (bus.cnt != r_sample);

  // Add-3 correction on every scratch nibble that is 5 or more.
  always_comb begin
    w_adj = r_scratch;
    for (int unsigned k = 0; k < 3; k++) begin
      if (r_scratch[k*4 +: 4] >= 4'd5)
        w_adj[k*4 +: 4] = r_scratch[k*4 +: 4] + 4'd3;
    end
  end

  assign w_shift = {w_adj, r_bin} << 1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = CONV;
      CONV:    if (r_iter == 3'd6) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sample  <= '0;
      r_bin     <= '0;
      r_scratch <= '0;
      r_iter    <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_sample  <= bus.cnt;
            r_bin     <= bus.cnt;
            r_scratch <= '0;
            r_iter    <= '0;
          end
        end
        CONV: begin
          r_scratch <= w_shift[18:7];
          r_bin     <= w_shift[6:0];
          r_iter    <= r_iter + 3'd1;
        end
        DONE: begin
          r_bcd  <= r_scratch;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Free-running scan; bcd updates never disturb the scan position.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pre   <= '0;
      r_digit <= '0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre   <= '0;
      r_digit <= (r_digit == 2'd2) ? 2'd0 : r_digit + 2'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  always_comb begin
    bus.an  = 3'b001;
    w_nib   = r_bcd[3:0];
    w_blank = 1'b0;
    case (r_digit)
      2'd1: begin
        bus.an = 3'b010;
        w_nib  = r_bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        bus.an = 3'b100;
        w_nib  = r_bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0);
`endif
      end
      default: ;
    endcase
    bus.seg = w_blank ? 7'h00 : seg_decode(w_nib);
  end

  assign bus.bcd       = r_bcd;
  assign bus.busy      = (r_state != IDLE);
  assign bus.conv_done = r_done;

endmodule

// File: tb/tb_cnt_bcd_display.sv
module tb_cnt_bcd_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cnt_bcd_display_if bus ();

  cnt_bcd_display #(.SCAN_DIV(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance until an equals the wanted value (bounded); leaves us on that negedge.
  task automatic wait_an(input logic [2:0] want, input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.an == want) break;
    end
    check(tag, 32'(bus.an), 32'(want));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          busy_cnt;
    int          pulses;
    logic [11:0] pbcd [2];
    logic [2:0]  exp_an  [3];
    logic [6:0]  exp_seg [3];
    logic [6:0]  exp_h;
    logic [6:0]  exp_t;

    // Reset
    bus.cnt = 7'd0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_bcd",  32'(bus.bcd), 32'h000);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.conv_done), 32'd0);
    check("rst_an",   32'(bus.an), 32'b001);
    check("rst_seg",  32'(bus.seg), 32'h3F);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
    end
    check("rst_no_conv", 32'(busy_cnt), 32'd0);

    // 0 -> 57: capture on E0, busy for 8 cycles, pulse after E8
    bus.cnt = 7'd57;
    busy_cnt = 0;
    pulses   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.conv_done) pulses++;
      if (i == 7) check("c57_done_e7", 32'(bus.conv_done), 32'd0);
      if (i == 8) begin
        check("c57_done_e8", 32'(bus.conv_done), 32'd1);
        check("c57_bcd",     32'(bus.bcd), 32'h057);
        check("c57_busy_e8", 32'(bus.busy), 32'd0);
      end
    end
    check("c57_busy_cycles", 32'(busy_cnt), 32'd8);
    check("c57_pulses",      32'(pulses), 32'd1);

    // 100 and scan sequence
    bus.cnt = 7'd100;
    repeat (12) @(negedge clk);
    check("c100_bcd", 32'(bus.bcd), 32'h100);
    exp_an[0] = 3'b001; exp_seg[0] = 7'h3F;
    exp_an[1] = 3'b010; exp_seg[1] = 7'h3F;
    exp_an[2] = 3'b100; exp_seg[2] = 7'h06;
    wait_an(3'b100, "scan_sync_h");
    wait_an(3'b001, "scan_sync_u");
    for (int c = 0; c < 13; c++) begin
      check($sformatf("scan_an_%0d", c),  32'(bus.an),  32'(exp_an[(c/4)%3]));
      check($sformatf("scan_seg_%0d", c), 32'(bus.seg), 32'(exp_seg[(c/4)%3]));
      @(negedge clk);
    end

    // 100 -> 57, then 58 during CONV: two conversions, two pulses
    bus.cnt = 7'd57;
    pulses  = 0;
    pbcd[0] = '0;
    pbcd[1] = '0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 2) bus.cnt = 7'd58;
      if (bus.conv_done) begin
        if (pulses < 2) pbcd[pulses] = bus.bcd;
        pulses++;
      end
    end
    check("chg_pulses", 32'(pulses), 32'd2);
    check("chg_bcd1",   32'(pbcd[0]), 32'h057);
    check("chg_bcd2",   32'(pbcd[1]), 32'h058);
    check("chg_final",  32'(bus.bcd), 32'h058);

    // Reset in the 4th CONV cycle of a 99 conversion
    bus.cnt = 7'd99;
    pulses  = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.conv_done) pulses++;
    end
    check("r99_busy_pre", 32'(bus.busy), 32'd1);
    rst     = 1'b1;
    bus.cnt = 7'd0;
    @(negedge clk);
    check("r99_bcd_rst",  32'(bus.bcd), 32'h000);
    check("r99_busy_rst", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.conv_done) pulses++;
      if (bus.busy) busy_cnt++;
    end
    check("r99_pulses", 32'(pulses), 32'd0);
    check("r99_busy",   32'(busy_cnt), 32'd0);
    check("r99_bcd",    32'(bus.bcd), 32'h000);

    // cnt = 7: leading-zero handling
`ifdef LEADING_ZERO_BLANK_EN
    exp_h = 7'h00;
    exp_t = 7'h00;
`else
    exp_h = 7'h3F;
    exp_t = 7'h3F;
`endif
    bus.cnt = 7'd7;
    repeat (12) @(negedge clk);
    check("c7_bcd", 32'(bus.bcd), 32'h007);
    wait_an(3'b100, "c7_an_h");
    check("c7_seg_h", 32'(bus.seg), 32'(exp_h));
    wait_an(3'b001, "c7_an_u");
    check("c7_seg_u", 32'(bus.seg), 32'h07);
    wait_an(3'b010, "c7_an_t");
    check("c7_seg_t", 32'(bus.seg), 32'(exp_t));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
